// File: rtl/debug_watch_unit_pkg.sv
// Shared constants and types for the debug breakpoint/watchpoint unit.
// Holds config field codes, control bit positions, index widths and the
// watch-channel control word layout.
package debug_watch_unit_pkg;

    localparam int unsigned IDX_W    = 4;
    localparam int unsigned HIT_ID_W = 4;
    localparam int unsigned FIELD_W  = 2;

    // Config field codes (breakpoint / watch meaning share encodings)
    localparam logic [FIELD_W-1:0] FLD_ADDR  = 2'd0;
    localparam logic [FIELD_W-1:0] FLD_START = 2'd0;
    localparam logic [FIELD_W-1:0] FLD_PASS  = 2'd1;
    localparam logic [FIELD_W-1:0] FLD_END   = 2'd1;
    localparam logic [FIELD_W-1:0] FLD_CTL   = 2'd2;

    // Control bit positions
    localparam int unsigned CTL_EN = 0;
    localparam int unsigned CTL_W  = 3;

    // Watch control word: bit0 enable, bit1 match RD, bit2 match WR
    typedef struct packed {
        logic wr;
        logic rd;
        logic en;
    } watch_ctl_t;

endpackage

// File: rtl/debug_bkp_channel.sv
// One instruction-address breakpoint channel: address compare, enable and
// pass counter. hit_c is combinational for the current FETCH cycle.
// Ports: clk, rst_n, fetch, addr (CPU bus), cfg_sel (write targets this
// channel), cfg_field, cfg_data, hit_c (match with exhausted pass counter).
module debug_bkp_channel
    import debug_watch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                cfg_sel,
    input  logic [FIELD_W-1:0]  cfg_field,
    input  logic [ADDR_W-1:0]   cfg_data,
    output logic                hit_c
);

    logic [ADDR_W-1:0] bkp_addr;
    logic [CNT_W-1:0]  pass_reload;
    logic [CNT_W-1:0]  pass_cnt;
    logic              enable;
    logic              match_c;

    assign match_c = fetch && enable && (addr == bkp_addr);
    assign hit_c   = match_c && (pass_cnt == '0);

    // Config registers and pass counter; a reload write overrides a decrement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bkp_addr    <= '0;
            pass_reload <= '0;
            pass_cnt    <= '0;
            enable      <= 1'b0;
        end else begin
            if (cfg_sel && cfg_field == FLD_ADDR) bkp_addr <= cfg_data;
            if (cfg_sel && cfg_field == FLD_PASS) pass_reload <= cfg_data[CNT_W-1:0];
            if (cfg_sel && cfg_field == FLD_CTL)  enable <= cfg_data[CTL_EN];

            if (cfg_sel && cfg_field == FLD_PASS) begin
                pass_cnt <= cfg_data[CNT_W-1:0];
            end else if (cfg_sel && cfg_field == FLD_CTL) begin
                pass_cnt <= pass_reload;
            end else if (match_c && pass_cnt != '0) begin
                pass_cnt <= pass_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/debug_watch_unit.sv
// Breakpoint/watchpoint unit beside the CPU phase sequencer. N_BKP fetch
// breakpoints with pass counters, N_WATCH data-address ranges with RD/WR
// qualification, sticky halt request with first-hit channel id.
// Ports: CLK, RESET_N, phase strobes FETCH/DECODE/EXECUTE/COMMIT, RD, WR,
// ADDR, config port CFG_WE/CFG_IDX/CFG_FIELD/CFG_DATA, DEBUG_ACK; outputs
// DEBUG_AT_BKP, DEBUG_IN_WATCH, DEBUG_HALT_REQ, DEBUG_HIT_ID.
module debug_watch_unit
    import debug_watch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned N_BKP   = 4,
    parameter int unsigned N_WATCH = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 FETCH,
    input  logic                 DECODE,
    input  logic                 EXECUTE,
    input  logic                 COMMIT,
    input  logic                 RD,
    input  logic                 WR,
    input  logic [ADDR_W-1:0]    ADDR,
    input  logic                 CFG_WE,
    input  logic [IDX_W-1:0]     CFG_IDX,
    input  logic [FIELD_W-1:0]   CFG_FIELD,
    input  logic [ADDR_W-1:0]    CFG_DATA,
    input  logic                 DEBUG_ACK,
    output logic                 DEBUG_AT_BKP,
    output logic                 DEBUG_IN_WATCH,
    output logic                 DEBUG_HALT_REQ,
    output logic [HIT_ID_W-1:0]  DEBUG_HIT_ID
);

    localparam int unsigned N_TOT = N_BKP + N_WATCH;

    logic [N_BKP-1:0]    bkp_hit_c;
    logic [N_WATCH-1:0]  watch_hit_c;
    logic [N_TOT-1:0]    hit_vec_c;
    logic [HIT_ID_W-1:0] first_id_c;

    logic [ADDR_W-1:0] w_start [N_WATCH];
    logic [ADDR_W-1:0] w_end   [N_WATCH];
    watch_ctl_t        w_ctl   [N_WATCH];

    // DECODE carries no information beyond the other one-hot strobes
    logic unused_decode;
    assign unused_decode = DECODE;

    // Breakpoint channels
    for (genvar g = 0; g < int'(N_BKP); g++) begin : g_bkp
        debug_bkp_channel #(
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk       (CLK),
            .rst_n     (RESET_N),
            .fetch     (FETCH),
            .addr      (ADDR),
            .cfg_sel   (CFG_WE && (32'(CFG_IDX) == 32'(g))),
            .cfg_field (CFG_FIELD),
            .cfg_data  (CFG_DATA),
            .hit_c     (bkp_hit_c[g])
        );
    end

    // Watch range config registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned j = 0; j < N_WATCH; j++) begin
                w_start[j] <= '0;
                w_end[j]   <= '0;
                w_ctl[j]   <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < N_WATCH; j++) begin
                if (CFG_WE && (32'(CFG_IDX) == N_BKP + j)) begin
                    case (CFG_FIELD)
                        FLD_START: w_start[j] <= CFG_DATA;
                        FLD_END:   w_end[j]   <= CFG_DATA;
                        FLD_CTL:   w_ctl[j]   <= watch_ctl_t'(CFG_DATA[CTL_W-1:0]);
                        default:   ;
                    endcase
                end
            end
        end
    end

    // Watch comparators; start > end can never satisfy both bounds
    always_comb begin
        watch_hit_c = '0;
        for (int unsigned j = 0; j < N_WATCH; j++) begin
            watch_hit_c[j] = EXECUTE && w_ctl[j].en
                          && ((RD && w_ctl[j].rd) || (WR && w_ctl[j].wr))
                          && (ADDR >= w_start[j]) && (ADDR <= w_end[j]);
        end
    end

    assign hit_vec_c = {watch_hit_c, bkp_hit_c};

    // Lowest index wins; breakpoints occupy the low indices
    always_comb begin
        first_id_c = '0;
        for (int i = int'(N_TOT) - 1; i >= 0; i--) begin
            if (hit_vec_c[i]) first_id_c = HIT_ID_W'(i);
        end
    end

    // Hit flags and sticky halt status; a new hit outranks a same-edge ACK
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DEBUG_AT_BKP   <= 1'b0;
            DEBUG_IN_WATCH <= 1'b0;
            DEBUG_HALT_REQ <= 1'b0;
            DEBUG_HIT_ID   <= '0;
        end else begin
            if (|bkp_hit_c)   DEBUG_AT_BKP <= 1'b1;
            else if (COMMIT)  DEBUG_AT_BKP <= 1'b0;

            if (|watch_hit_c) DEBUG_IN_WATCH <= 1'b1;
            else if (COMMIT)  DEBUG_IN_WATCH <= 1'b0;

            if ((|hit_vec_c) && (!DEBUG_HALT_REQ || DEBUG_ACK)) begin
                DEBUG_HALT_REQ <= 1'b1;
                DEBUG_HIT_ID   <= first_id_c;
            end else if (DEBUG_ACK) begin
                DEBUG_HALT_REQ <= 1'b0;
                DEBUG_HIT_ID   <= '0;
            end
        end
    end

endmodule
